// File: rtl/ipg_pkg.sv
// Shared types and constants for the TX IPG chunk arbiter.
package ipg_pkg;

  localparam int unsigned IPG_CHUNK_W = 64;

  // tuser back-pressure bit positions from eth_phy_10g_tx
  localparam int unsigned TUSER_AFULL = 0;
  localparam int unsigned TUSER_FULL  = 1;

  // burst counter width, enough for BURST_MAX up to 15
  localparam int unsigned BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    STALL = 2'd2
  } ipg_state_e;

endpackage

// File: rtl/ipg_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ipg_rr_pick #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // scan from the pointer upward; the first hit wins
  always_comb begin
    int unsigned j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/ipg_chunk_arb.sv
// Round-robin arbiter sharing the TX IPG chunk path between several producers.
module ipg_chunk_arb
  import ipg_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned DATA_WIDTH = IPG_CHUNK_W,
  parameter  int unsigned BURST_MAX  = 4,
  parameter  int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         ipg_reply_chunk,
  output logic                          memq_write,
  input  logic [1:0]                    tuser,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic                          burst_trunc,
  output logic [CNT_WIDTH-1:0]          chunk_count
);

  ipg_state_e state_q, state_d;

  logic [IDX_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] gnt_oh_q;
  logic [BURST_W-1:0] burst_cnt_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic                  xfer_ok;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  burst_hit;
  logic                  grant_start;
  logic                  grant_end;
  logic                  trunc;

  ipg_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_start) state_d = XFER;
      XFER: begin
        if (grant_end)             state_d = IDLE;
        else if (tuser[TUSER_FULL]) state_d = STALL;
      end
      STALL:   if (!tuser[TUSER_FULL]) state_d = XFER;
      default: state_d = IDLE;
    endcase
  end

  // handshake decode: grantee mux, accept, grant start/end conditions
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh_q[i]) begin
        sel_valid = sel_valid | req_valid[i];
        sel_last  = sel_last | req_last[i];
        sel_data  = sel_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    xfer_ok     = (state_q == XFER) && !tuser[TUSER_FULL];
    accept      = xfer_ok && sel_valid;
    burst_hit   = (burst_cnt_q == BURST_W'(BURST_MAX - 1));
    grant_end   = accept && (sel_last || burst_hit);
    trunc       = accept && burst_hit && !sel_last;
    grant_start = (state_q == IDLE) && (tuser == 2'b00) && pick_any;
    req_ready   = gnt_oh_q & {NUM_REQ{xfer_ok}};
  end

  assign busy = (state_q != IDLE);

  // grant bookkeeping: grantee, RR pointer, burst counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q    <= '0;
      gnt_oh_q    <= '0;
      grant_id    <= '0;
      burst_cnt_q <= '0;
    end else begin
      if (grant_start) begin
        gnt_oh_q    <= pick_oh;
        grant_id    <= pick_idx;
        burst_cnt_q <= '0;
      end else if (accept) begin
        burst_cnt_q <= burst_cnt_q + BURST_W'(1);
      end
      if (grant_end) begin
        rr_ptr_q <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + IDX_W'(1);
      end
    end
  end

  // registered chunk stream and statistics toward TX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memq_write      <= 1'b0;
      ipg_reply_chunk <= '0;
      burst_trunc     <= 1'b0;
      chunk_count     <= '0;
    end else begin
      memq_write  <= accept;
      burst_trunc <= trunc;
      if (accept) begin
        ipg_reply_chunk <= sel_data;
        chunk_count     <= chunk_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ipg_chunk_arb.sv
// Bench for ipg_chunk_arb: directed scenarios plus random traffic vs a message-level model.
module tb_ipg_chunk_arb;

  localparam int NR = 2;
  localparam int DW = 64;
  localparam int BM = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]   ipg_reply_chunk;
  logic            memq_write;
  logic [1:0]      tuser;
  logic [0:0]      grant_id;
  logic            busy, burst_trunc;
  logic [CW-1:0]   chunk_count;

  ipg_chunk_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .ipg_reply_chunk(ipg_reply_chunk), .memq_write(memq_write),
    .tuser(tuser), .grant_id(grant_id), .busy(busy),
    .burst_trunc(burst_trunc), .chunk_count(chunk_count)
  );

  always #5 clk = ~clk;

  // producer message queues and expected output stream
  logic [DW-1:0] pdata [NR][$];
  bit            plast [NR][$];
  int            pidx  [NR];
  logic [DW-1:0] exp_d [$];
  int            exp_g [$];
  int            mptr, exp_trunc, trunc_seen, n_chk, n_fail, t0;
  logic [CW-1:0] exp_total;
  logic          prev_acc;
  logic [DW-1:0] last_out;
  int            gcount [NR];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (pidx[i] < pdata[i].size()) begin
        req_valid[i]           = 1'b1;
        req_last[i]            = plast[i][pidx[i]];
        req_data[i*DW +: DW]   = pdata[i][pidx[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic clear_prod();
    for (int i = 0; i < NR; i++) begin
      pdata[i].delete();
      plast[i].delete();
      pidx[i] = 0;
    end
  endtask

  task automatic load(input int r, input int len, input int tag);
    for (int c = 0; c < len; c++) begin
      pdata[r].push_back({8'(r), 8'(tag), 16'(c), 32'($urandom)});
      plast[r].push_back(c == len - 1);
    end
  endtask

  // message-level reference: RR over requesters that still hold chunks, capped bursts
  task automatic model();
    int pos [NR];
    int g, n, j;
    bit found, lst;
    for (int i = 0; i < NR; i++) pos[i] = pidx[i];
    g = 0;
    while (1) begin
      found = 0;
      for (int k = 0; k < NR; k++) begin
        j = (mptr + k) % NR;
        if (!found && pos[j] < pdata[j].size()) begin
          found = 1;
          g = j;
        end
      end
      if (!found) break;
      n = 0;
      lst = 0;
      while (!lst && n < BM && pos[g] < pdata[g].size()) begin
        exp_d.push_back(pdata[g][pos[g]]);
        exp_g.push_back(g);
        lst = plast[g][pos[g]];
        pos[g]++;
        n++;
        exp_total++;
      end
      if (!lst && n == BM) exp_trunc++;
      mptr = (g + 1) % NR;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (pidx[i] < pdata[i].size()) return 1'b1;
    return 1'b0;
  endfunction

  // one clock: check outputs at negedge, then advance producers after the edge
  task automatic step();
    logic [NR-1:0] acc;
    logic [DW-1:0] ed;
    int g;
    @(negedge clk);
    if (tuser[1]) chk("ready_when_full", DW'(req_ready), '0);
    chk("ready_onehot0", DW'($onehot0(req_ready)), DW'(1));
    chk("write_latency", DW'(memq_write), DW'(prev_acc));
    if (memq_write) begin
      if (exp_d.size() == 0) begin
        chk("unexpected_write", DW'(memq_write), '0);
      end else begin
        ed = exp_d.pop_front();
        g  = exp_g.pop_front();
        chk("chunk_data", ipg_reply_chunk, ed);
        chk("chunk_grant", DW'(grant_id), DW'(g));
        gcount[grant_id]++;
      end
      last_out = ipg_reply_chunk;
    end else begin
      chk("data_hold", ipg_reply_chunk, last_out);
    end
    if (burst_trunc) trunc_seen++;
    acc      = req_valid & req_ready;
    prev_acc = |acc;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) pidx[i]++;
    drive();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_d.size() != 0 || pending()) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, DW'(n < budget), DW'(1));
    repeat (3) step();
    chk({tag, "_trunc"}, DW'(trunc_seen), DW'(exp_trunc));
    chk({tag, "_count"}, DW'(chunk_count), DW'(exp_total));
    chk({tag, "_idle"}, DW'(busy), '0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_memq_write"}, DW'(memq_write), '0);
    chk({tag, "_chunk"}, ipg_reply_chunk, '0);
    chk({tag, "_grant_id"}, DW'(grant_id), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_trunc"}, DW'(burst_trunc), '0);
    chk({tag, "_count"}, DW'(chunk_count), '0);
    chk({tag, "_ready"}, DW'(req_ready), '0);
  endtask

  task automatic clear_model();
    exp_d.delete();
    exp_g.delete();
    mptr = 0; exp_total = '0; exp_trunc = 0; trunc_seen = 0;
    prev_acc = 1'b0; last_out = '0;
  endtask

  initial begin
    int n;
    rst = 1'b0; tuser = 2'b00;
    req_valid = '0; req_last = '0; req_data = '0;
    n_chk = 0; n_fail = 0;
    clear_prod();
    clear_model();
    for (int i = 0; i < NR; i++) gcount[i] = 0;
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    drive();

    // single requester, 3-chunk message
    clear_prod(); load(0, 3, 1); model();
    drain(40, "single");
    chk("single_count3", DW'(chunk_count), DW'(3));
    chk("single_no_trunc", DW'(trunc_seen), '0);

    // both requesters, 1-chunk messages: alternate and share equally
    clear_prod();
    for (int m = 0; m < 4; m++) begin load(0, 1, 2 + m); load(1, 1, 6 + m); end
    for (int i = 0; i < NR; i++) gcount[i] = 0;
    model();
    drain(80, "alt");
    chk("alt_share0", DW'(gcount[0]), DW'(4));
    chk("alt_share1", DW'(gcount[1]), DW'(4));

    // 6-chunk message truncated at BURST_MAX, other requester interleaves
    clear_prod(); t0 = trunc_seen;
    load(0, 1, 10); load(1, 6, 11); load(0, 1, 12);
    model();
    drain(80, "trunc");
    chk("trunc_pulse_once", DW'(trunc_seen - t0), DW'(1));

    // last coincides with BURST_MAX: normal end
    clear_prod(); t0 = trunc_seen;
    load(1, 4, 20); model();
    drain(40, "last_at_max");
    chk("last_at_max_no_trunc", DW'(trunc_seen - t0), '0);

    // full back-pressure mid-message for 5 cycles, burst count preserved
    clear_prod(); t0 = trunc_seen;
    load(0, 6, 30); load(1, 1, 31); model();
    repeat (3) step();
    tuser = 2'b10;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_busy", DW'(busy), DW'(1));
      chk("stall_no_write", DW'(memq_write), '0);
    end
    tuser = 2'b00;
    drain(80, "stall");
    chk("stall_trunc_kept", DW'(trunc_seen - t0), DW'(1));

    // almost-full blocks new grants but not an ongoing one
    clear_prod(); t0 = trunc_seen;
    tuser = 2'b01;
    load(1, 4, 40); model();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("afull_no_grant", DW'(busy), '0);
    end
    tuser = 2'b00;
    step(); step();
    tuser = 2'b01;
    drain(40, "afull_xfer");
    tuser = 2'b00;

    // reset mid-burst: outputs clear at once, RR pointer back to 0
    clear_prod();
    load(0, 1, 50); load(1, 6, 51); model();
    n = 0;
    while (pidx[1] < 2 && n < 40) begin step(); n++; end
    chk("pre_reset_reach", DW'(n < 40), DW'(1));
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check_zero("midreset");
    clear_prod(); clear_model(); drive();
    @(posedge clk); #1;
    rst = 1'b1;
    load(0, 1, 60); load(1, 1, 61); model();
    drain(40, "post_reset");

    // random messages and random back-pressure
    for (int round = 0; round < 6; round++) begin
      clear_prod();
      for (int r = 0; r < NR; r++) begin
        int nm;
        nm = int'($urandom_range(1, 3));
        for (int m = 0; m < nm; m++) load(r, int'($urandom_range(1, 7)), 100 + round * 8 + m);
      end
      model();
      n = 0;
      while ((exp_d.size() != 0 || pending()) && n < 2000) begin
        tuser = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(1, 3));
        step();
        n++;
      end
      tuser = 2'b00;
      drain(200, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
